// File: rtl/otter_lsu_pkg.sv
// Shared types and constants for the OTTER load/store unit.
package otter_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [1:0]  SIZE_BYTE       = 2'd0;
  localparam logic [1:0]  SIZE_HALF       = 2'd1;
  localparam logic [1:0]  SIZE_WORD       = 2'd2;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h00010000;

endpackage

// File: rtl/otter_lsu_align_chk.sv
// Alignment / size legality check for one data-port access.
module otter_lsu_align_chk
  import otter_lsu_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] size,
  input  logic       strict_align,
  output logic       err
);

  always_comb begin
    err = 1'b0;
    case (size)
      SIZE_BYTE: err = 1'b0;
      // Relaxed mode still refuses a halfword that would straddle a word.
      SIZE_HALF: err = strict_align ? addr[0] : (addr == 2'd3);
      SIZE_WORD: err = (addr != 2'd0);
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/otter_lsu.sv
// Load/store unit driving port 2 of the OTTER BRAM; one request in flight.
// state | meaning
// IDLE  | ready for a request
// ISSUE | memory enable asserted for one cycle
// WAIT  | synchronous read in progress, address held
// RESP  | response presented until consumed
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT,
  parameter bit          STRICT_ALIGN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGN,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_DATA,
  output logic        RSP_ERR,
  output logic        RSP_IO,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  lsu_state_t state, state_nx;
  logic       accept;
  logic       mis_err;
  logic       we_q;

  otter_lsu_align_chk u_align_chk (
    .addr         (REQ_ADDR[1:0]),
    .size         (REQ_SIZE),
    .strict_align (STRICT_ALIGN),
    .err          (mis_err)
  );

  // REQ_READY is a flop, so it also gates acceptance in the first cycle after reset.
  assign accept = (state == IDLE) && REQ_READY && REQ_VALID;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = mis_err ? RESP : ISSUE;
      ISSUE:   state_nx = we_q ? RESP : WAIT;
      WAIT:    state_nx = RESP;
      RESP:    if (RSP_READY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      REQ_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
      RSP_IO    <= 1'b0;
      MEM_RDEN2 <= 1'b0;
      MEM_WE2   <= 1'b0;
      MEM_ADDR2 <= '0;
      MEM_DIN2  <= '0;
      MEM_SIZE  <= '0;
      MEM_SIGN  <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      REQ_READY <= (state_nx == IDLE);
      RSP_VALID <= (state_nx == RESP);
      MEM_RDEN2 <= accept && !mis_err && !REQ_WE;
      MEM_WE2   <= accept && !mis_err && REQ_WE;
      if (accept) begin
        we_q     <= REQ_WE;
        RSP_ERR  <= mis_err;
        RSP_IO   <= (REQ_ADDR >= IO_BASE);
        RSP_DATA <= '0;
        // Rejected accesses leave the memory port untouched.
        if (!mis_err) begin
          MEM_ADDR2 <= REQ_ADDR;
          MEM_SIZE  <= REQ_SIZE;
          MEM_SIGN  <= REQ_SIGN;
          if (REQ_WE) MEM_DIN2 <= REQ_WDATA;
        end
      end
      if (state == WAIT) RSP_DATA <= MEM_DOUT2;
    end
  end

endmodule

// File: tb/tb_otter_lsu.sv
// Directed plus random bench for otter_lsu against a byte-level memory reference.
module tb_otter_lsu;

  localparam logic [31:0] IO_BASE = 32'h00010000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WE = 1'b0;
  logic [31:0] REQ_ADDR = '0;
  logic [1:0]  REQ_SIZE = '0;
  logic        REQ_SIGN = 1'b0;
  logic [31:0] REQ_WDATA = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [31:0] RSP_DATA;
  logic        RSP_ERR;
  logic        RSP_IO;
  logic        MEM_RDEN2;
  logic        MEM_WE2;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  int checks = 0;
  int errors = 0;

  otter_lsu #(.IO_BASE(IO_BASE), .STRICT_ALIGN(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_SIZE(REQ_SIZE), .REQ_SIGN(REQ_SIGN),
    .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_ERR(RSP_ERR), .RSP_IO(RSP_IO),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
    .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2)
  );

  always #5 CLK = ~CLK;

  // OTTER-like port 2: registered word, sized with the live address/size.
  logic [31:0] ram [0:1023];
  logic [31:0] io_in = '0;
  logic [31:0] rd_word = '0;
  int rd_cnt = 0, we_cnt = 0, io_wr_cnt = 0, both_cnt = 0;

  function automatic logic [31:0] mem_extract(input logic [31:0] w, input logic [1:0] a,
                                              input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = w[16*a[1] +: 16];
    case (sz)
      2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign MEM_DOUT2 = mem_extract(rd_word, MEM_ADDR2[1:0], MEM_SIZE, MEM_SIGN);

  always @(posedge CLK) begin
    if (MEM_RDEN2) rd_word <= (MEM_ADDR2 >= IO_BASE) ? io_in : ram[MEM_ADDR2[11:2]];
    if (MEM_WE2) begin
      if (MEM_ADDR2 >= IO_BASE) io_wr_cnt <= io_wr_cnt + 1;
      else case (MEM_SIZE)
        2'd0:    ram[MEM_ADDR2[11:2]][8*MEM_ADDR2[1:0] +: 8] <= MEM_DIN2[7:0];
        2'd1:    ram[MEM_ADDR2[11:2]][16*MEM_ADDR2[1] +: 16] <= MEM_DIN2[15:0];
        default: ram[MEM_ADDR2[11:2]] <= MEM_DIN2;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (MEM_RDEN2) rd_cnt <= rd_cnt + 1;
    if (MEM_WE2) we_cnt <= we_cnt + 1;
    if (MEM_RDEN2 && MEM_WE2) both_cnt <= both_cnt + 1;
  end

  // Reference: flat byte array for RAM; IO reads see io_in as a little-endian word.
  byte unsigned ref_bytes [0:4095];

  function automatic bit ref_err(input int unsigned addr, input int size);
    return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_load(input int unsigned addr, input int size, input bit uns);
    int n;
    longint v;
    longint b;
    n = 1 << size;
    v = 0;
    for (int i = 0; i < n; i++) begin
      if (addr >= IO_BASE) b = (longint'(io_in) >> (8 * ((addr + i) % 4))) & 255;
      else                 b = ref_bytes[addr + i];
      v = v + (b << (8 * i));
    end
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge CLK);
    while (!REQ_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!REQ_READY) check("req_ready_timeout", {31'h0, REQ_READY}, 32'h1);
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input int size,
                        input bit uns, input logic [31:0] wdata, input int hold);
    bit          err, io;
    logic [31:0] exp;
    int          lat, exp_lat, rd0, we0, io0;
    err = ref_err(addr, size);
    io  = (addr >= IO_BASE);
    exp = (we || err) ? 32'h0 : ref_load(addr, size, uns);
    exp_lat = err ? 1 : (we ? 2 : 3);
    wait_ready();
    rd0 = rd_cnt; we0 = we_cnt; io0 = io_wr_cnt;
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_SIZE = size[1:0];
    REQ_SIGN = uns; REQ_WDATA = wdata;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    lat = 1;
    while (!RSP_VALID && lat < 8) begin
      if (!err) begin
        check("mem_addr_held", MEM_ADDR2, addr);
        check("mem_size_held", {30'h0, MEM_SIZE}, size);
      end
      @(posedge CLK); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("rsp_valid", {31'h0, RSP_VALID}, 32'h1);
    check("rsp_data", RSP_DATA, exp);
    check("rsp_err", {31'h0, RSP_ERR}, {31'h0, err});
    check("rsp_io", {31'h0, RSP_IO}, {31'h0, io});
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check("hold_valid", {31'h0, RSP_VALID}, 32'h1);
      check("hold_data", RSP_DATA, exp);
      check("hold_req_ready", {31'h0, REQ_READY}, 32'h0);
    end
    @(negedge CLK);
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    check("idle_req_ready", {31'h0, REQ_READY}, 32'h1);
    check("idle_rsp_valid", {31'h0, RSP_VALID}, 32'h0);
    check("rden_pulses", rd_cnt - rd0, (!we && !err) ? 1 : 0);
    check("we_pulses", we_cnt - we0, (we && !err) ? 1 : 0);
    check("io_wr_pulses", io_wr_cnt - io0, (we && !err && io) ? 1 : 0);
    if (we && !err && !io)
      for (int i = 0; i < (1 << size); i++) ref_bytes[addr + i] = wdata[8*i +: 8];
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {REQ_READY, RSP_VALID, RSP_ERR, RSP_IO, MEM_RDEN2, MEM_WE2, MEM_SIZE, MEM_SIGN}, 32'h0);
    check(tag, RSP_DATA | MEM_ADDR2 | MEM_DIN2, 32'h0);
  endtask

  initial begin
    int unsigned a;
    int sz;
    bit w;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset_outputs");
    @(negedge CLK);
    RST = 1'b0;

    do_req(1'b1, 32'h100, 2, 1'b0, 32'hDEADBEEF, 0);
    do_req(1'b0, 32'h100, 2, 1'b0, 32'h0, 0);
    do_req(1'b0, 32'h103, 0, 1'b0, 32'h0, 0);
    do_req(1'b0, 32'h102, 1, 1'b1, 32'h0, 0);
    do_req(1'b0, 32'h101, 1, 1'b0, 32'h0, 0);
    do_req(1'b1, 32'h102, 2, 1'b0, 32'h11223344, 0);
    check("ram_unchanged", ram[32'h100 >> 2], 32'hDEADBEEF);
    io_in = 32'h12345678;
    do_req(1'b0, 32'h00011000, 2, 1'b0, 32'h0, 0);
    do_req(1'b1, 32'h00010000, 2, 1'b0, 32'hCAFEF00D, 0);
    do_req(1'b0, 32'h100, 2, 1'b0, 32'h0, 5);

    // Reset while the read is in flight.
    wait_ready();
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 32'h100; REQ_SIZE = 2'd2; REQ_SIGN = 1'b0;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    check_all_zero("reset_in_wait");
    @(negedge CLK);
    RST = 1'b0;
    do_req(1'b0, 32'h100, 2, 1'b0, 32'h0, 0);

    for (int n = 0; n < 60; n++) begin
      w  = $urandom_range(0, 1);
      sz = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = IO_BASE + $urandom_range(0, 255);
      else                           a = $urandom_range(0, 4092);
      if (sz == 2 && $urandom_range(0, 2) != 0) a = a & ~32'h3;
      if (sz == 1 && $urandom_range(0, 2) != 0) a = a & ~32'h1;
      if (a >= IO_BASE) io_in = $urandom;
      do_req(w, a, sz, 1'(($urandom_range(0, 1))), $urandom, $urandom_range(0, 2));
    end

    check("enables_never_both", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
